skinny_round_ctrl: RTL and testbench
====================================

# skinny_round_ctrl

Sequencer for the 32-bit serial Romulus-N datapath. On each `start` it:
- loads state and tweakey words,
- runs the 40 SKINNY-128-384+ rounds,
- restores and optionally advances the tweakey/counter,
- streams the result out.

It drives every enable, select and round-constant input of the datapath top. It sits between the Romulus mode FSM (the upstream requester) and the datapath.

## Interface
Parameters:
- `ROUNDS`, 40, number of SKINNY rounds per block
- `BEATS`, 4, 32-bit words per 128-bit load/unload

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request one block; accepted only in IDLE
- `mode_decrypt`  in  4  decrypt nibble; latched on accept
- `mode_domain`  in  8  domain byte; latched on accept
- `mode_tk1s`  in  1  include TK3/counter lane in round key; latched on accept
- `inc_cnt`  in  1  advance the 56-bit counter in REVERT; latched on accept
- `pdi_valid`  in  1  load word available
- `pdo_ready`  in  1  output word consumed
- `pdi_ready`  out  1  high in LOAD
- `pdo_valid`  out  1  high in UNLOAD
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last unload beat
- `srst`, `senc`, `sse`  out  1 each  state register controls
- `xrst`, `xenc`, `xse`  out  1 each  TK2 register controls
- `yrst`, `yenc`, `yse`  out  1 each  TK1 register controls
- `zrst`, `zenc`, `zse`  out  1 each  TK3/counter register controls
- `correct_cnt`  out  1  counter-LFSR source select
- `tk1s`  out  1  TK3 lane enable
- `constant`  out  6  SKINNY round constant
- `domain`  out  8  domain byte to the counter LFSR
- `decrypt`  out  4  decrypt nibble to the state unit

## Operation
FSM states: IDLE, LOAD, ROUND, REVERT, UNLOAD.

- **Register outputs.** All datapath control outputs are registered.
- **Reset (`rst` high).**
  - Go to IDLE. Beat counter and round counter go to 0; `rc` goes to 6'h01.
  - Latches (`decrypt`/`domain`/`tk1s`/`inc_cnt`) go to 0.
  - `srst`, `xrst`, `yrst`, `zrst` are 1 during the reset cycle.
  - Every other output is 0.
- **IDLE.** All enables are 0.
  - `start`=1 latches the mode inputs, clears the beat counter and moves to LOAD.
  - `start` in any other state is ignored, not queued.
- **LOAD.**
  - Per cycle with `pdi_valid`=1: `sse`=`xse`=`yse`=1 (shift in `pdi`/`sdi`) and the beat counter increments.
  - With `pdi_valid`=0 the enables are 0 and the counter holds.
  - After beat `BEATS`-1 is accepted: go to ROUND, round counter=0, `rc`=6'h01.
- **ROUND.** Every cycle `senc`=`xenc`=`yenc`=`zenc`=1, `constant`=`rc`, and `tk1s`=latched value.
  - `rc` update: `rc <= {rc[4:0], ~(rc[5]^rc[4])}`.
  - Required constant sequence starts 01,03,07,0F,1F,3E,3D,… and round 40 uses 1A.
  - After round `ROUNDS`-1: go to REVERT.
- **REVERT.** One cycle.
  - `xse`=`yse`=`zse`=1 restores TK1/TK2/TK3 to their pre-round values.
  - `correct_cnt`=latched `inc_cnt`: 1 loads LFSR(counter) and advances it; 0 loads the reverted value.
  - `domain` is valid this cycle. Next state: UNLOAD, beat counter=0.
- **UNLOAD.**
  - Per cycle with `pdo_ready`=1: `sse`=1 and the beat counter increments.
  - `decrypt`=latched nibble during all of UNLOAD; 0 otherwise.
  - After beat `BEATS`-1 is consumed: go to IDLE and pulse `done`.
- **Outside the active phase.** `constant`=0 outside ROUND. `domain` holds its latched value while busy and is 0 in IDLE.
- **Counter clear.** `zrst` is asserted only by `rst`, so the counter persists across blocks.

## Timing
- Accept edge E0. With no stalls:
  - LOAD occupies cycles 1–4.
  - ROUND occupies 5–44.
  - REVERT occupies 45.
  - UNLOAD occupies 46–49.
  - `done`=1 in cycle 50, with `busy`=0 that cycle.
- Each LOAD/UNLOAD cycle with the handshake deasserted adds exactly one cycle.
- ROUND and REVERT never stall.
- A new `start` may be asserted in the `done` cycle and is accepted there (back-to-back, zero bubble).
- Mutual exclusion: `senc` and `sse` are never 1 in the same cycle. `xse` and `xenc` are never 1 in the same cycle.
- `rst` mid-operation takes effect at the next edge. No partial beats complete after that edge.

## Test plan
- **Reset.** Hold `rst` 2 cycles, then idle 5 cycles → `busy`=`done`=0; all enables 0 after release; `constant`=0.
- **Single block, no stalls.** `start`, `pdi_valid`=`pdo_ready`=1 →
  - `sse` high cycles 1–4;
  - constants 01,03,07,…,2D,1A in cycles 5–44;
  - REVERT at 45;
  - `done` pulse at 50.
- **Stalls.** `pdi_valid` low on beat 2 for 3 cycles and `pdo_ready` low on beat 0 for 2 cycles → `done` at cycle 55; `sse` count exactly 4 in LOAD and 4 in UNLOAD.
- **Counter advance.** `inc_cnt`=1, `mode_domain`=8'h2C → `correct_cnt`=1, `zse`=1 and `domain`=2C only in REVERT.
- **Repeat with counter hold.** Rerun with `inc_cnt`=0 → `correct_cnt`=0 in REVERT.
- **Back-to-back and ignored start.** `start` in the `done` cycle → second block LOAD starts the next cycle. `start` held during ROUND → no effect.
- **Reset mid-round.** `rst` at round 20 → IDLE next cycle, `rc` reset; a fresh `start` reproduces the full constant sequence from 01.

Source files
------------

// File: rtl/skinny_round_ctrl.sv
// ---------------------------------------------------------------------------
// skinny_round_ctrl
//
// Sequencer for the 32-bit serial Romulus-N / SKINNY-128-384+ datapath.
// Per accepted start it walks LOAD -> ROUND -> REVERT -> UNLOAD and drives
// every enable, select and round-constant input of the datapath.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 block request, accepted only in IDLE
//   mode_decrypt/domain/  mode fields, latched on accept
//   mode_tk1s, inc_cnt
//   pdi_valid/pdi_ready   load-word handshake (ready high in LOAD)
//   pdo_valid/pdo_ready   unload-word handshake (valid high in UNLOAD)
//   busy, done            status; done pulses one cycle after last unload
//   s*/x*/y*/z*           state / TK2 / TK1 / TK3-counter register controls
//   correct_cnt, tk1s     counter LFSR source select, TK3 lane enable
//   constant              SKINNY round constant (0 outside ROUND)
//   domain, decrypt       domain byte / decrypt nibble to the datapath
// ---------------------------------------------------------------------------
module skinny_round_ctrl #(
  parameter int ROUNDS = 40,
  parameter int BEATS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mode_decrypt,
  input  logic [7:0] mode_domain,
  input  logic       mode_tk1s,
  input  logic       inc_cnt,
  input  logic       pdi_valid,
  input  logic       pdo_ready,
  output logic       pdi_ready,
  output logic       pdo_valid,
  output logic       busy,
  output logic       done,
  output logic       srst,
  output logic       senc,
  output logic       sse,
  output logic       xrst,
  output logic       xenc,
  output logic       xse,
  output logic       yrst,
  output logic       yenc,
  output logic       yse,
  output logic       zrst,
  output logic       zenc,
  output logic       zse,
  output logic       correct_cnt,
  output logic       tk1s,
  output logic [5:0] constant,
  output logic [7:0] domain,
  output logic [3:0] decrypt
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);
  localparam logic [5:0]    RC_INIT    = 6'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_REVERT,
    S_UNLOAD
  } state_t;

  // Sequencer state
  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [RW-1:0]  rnd_q, rnd_d;
  logic [5:0]     rc_q, rc_d;

  // Mode fields captured on accept
  logic [3:0]     dec_lat_q, dec_lat_d;
  logic [7:0]     dom_lat_q, dom_lat_d;
  logic           tk1s_lat_q, tk1s_lat_d;
  logic           inc_lat_q, inc_lat_d;

  // Registered control outputs
  logic           res_q;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pdi_ready_q, pdi_ready_d;
  logic           pdo_valid_q, pdo_valid_d;
  logic           round_en_q, round_en_d;
  logic           revert_q, revert_d;
  logic           correct_cnt_q, correct_cnt_d;
  logic           tk1s_q, tk1s_d;
  logic [5:0]     constant_q, constant_d;
  logic [7:0]     domain_q, domain_d;
  logic [3:0]     decrypt_q, decrypt_d;

  // Next-state and next-output logic. Outputs are computed from the next
  // state so that each register already reflects the state it belongs to.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    rnd_d      = rnd_q;
    rc_d       = rc_q;
    dec_lat_d  = dec_lat_q;
    dom_lat_d  = dom_lat_q;
    tk1s_lat_d = tk1s_lat_q;
    inc_lat_d  = inc_lat_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dec_lat_d  = mode_decrypt;
          dom_lat_d  = mode_domain;
          tk1s_lat_d = mode_tk1s;
          inc_lat_d  = inc_cnt;
          beat_d     = '0;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (pdi_valid) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            rnd_d   = '0;
            rc_d    = RC_INIT;
            state_d = S_ROUND;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      S_ROUND: begin
        // 6-bit SKINNY round-constant LFSR
        rc_d = {rc_q[4:0], ~(rc_q[5] ^ rc_q[4])};
        if (rnd_q == ROUND_LAST) begin
          state_d = S_REVERT;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end

      S_REVERT: begin
        beat_d  = '0;
        state_d = S_UNLOAD;
      end

      S_UNLOAD: begin
        if (pdo_ready) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d        = (state_d != S_IDLE);
    pdi_ready_d   = (state_d == S_LOAD);
    pdo_valid_d   = (state_d == S_UNLOAD);
    round_en_d    = (state_d == S_ROUND);
    revert_d      = (state_d == S_REVERT);
    correct_cnt_d = (state_d == S_REVERT) & inc_lat_d;
    tk1s_d        = (state_d == S_ROUND) & tk1s_lat_d;
    constant_d    = (state_d == S_ROUND) ? rc_d : 6'h00;
    domain_d      = (state_d != S_IDLE) ? dom_lat_d : 8'h00;
    decrypt_d     = (state_d == S_UNLOAD) ? dec_lat_d : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      rnd_q         <= '0;
      rc_q          <= RC_INIT;
      dec_lat_q     <= 4'h0;
      dom_lat_q     <= 8'h00;
      tk1s_lat_q    <= 1'b0;
      inc_lat_q     <= 1'b0;
      res_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pdi_ready_q   <= 1'b0;
      pdo_valid_q   <= 1'b0;
      round_en_q    <= 1'b0;
      revert_q      <= 1'b0;
      correct_cnt_q <= 1'b0;
      tk1s_q        <= 1'b0;
      constant_q    <= 6'h00;
      domain_q      <= 8'h00;
      decrypt_q     <= 4'h0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      rnd_q         <= rnd_d;
      rc_q          <= rc_d;
      dec_lat_q     <= dec_lat_d;
      dom_lat_q     <= dom_lat_d;
      tk1s_lat_q    <= tk1s_lat_d;
      inc_lat_q     <= inc_lat_d;
      res_q         <= 1'b0;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pdi_ready_q   <= pdi_ready_d;
      pdo_valid_q   <= pdo_valid_d;
      round_en_q    <= round_en_d;
      revert_q      <= revert_d;
      correct_cnt_q <= correct_cnt_d;
      tk1s_q        <= tk1s_d;
      constant_q    <= constant_d;
      domain_q      <= domain_d;
      decrypt_q     <= decrypt_d;
    end
  end

  // Shift enables in LOAD/UNLOAD are the registered phase flag qualified by
  // the live handshake, so a word shifts exactly in the cycle it is
  // transferred and a stalled cycle shifts nothing.
  logic load_shift;
  logic unload_shift;
  assign load_shift   = pdi_ready_q & pdi_valid;
  assign unload_shift = pdo_valid_q & pdo_ready;

  // Register clears come only from rst; the counter lane (z) therefore
  // keeps its value from block to block.
  assign srst = res_q;
  assign xrst = res_q;
  assign yrst = res_q;
  assign zrst = res_q;

  assign senc = round_en_q;
  assign xenc = round_en_q;
  assign yenc = round_en_q;
  assign zenc = round_en_q;

  assign sse  = load_shift | unload_shift;
  // REVERT reloads TK1/TK2/TK3 from their shadow path via the shift input
  assign xse  = load_shift | revert_q;
  assign yse  = load_shift | revert_q;
  assign zse  = revert_q;

  assign pdi_ready   = pdi_ready_q;
  assign pdo_valid   = pdo_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign correct_cnt = correct_cnt_q;
  assign tk1s        = tk1s_q;
  assign constant    = constant_q;
  assign domain      = domain_q;
  assign decrypt     = decrypt_q;

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_skinny_round_ctrl
//
// Scoreboard bench. The driver issues blocks with planned handshake stalls
// and pushes the expected round constants, REVERT controls, unload decrypt
// nibbles and done cycle into queues; a negedge monitor pops and compares
// whenever the DUT shows the matching activity.
// ---------------------------------------------------------------------------
module tb_skinny_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mode_decrypt = 4'h0;
  logic [7:0] mode_domain = 8'h00;
  logic       mode_tk1s = 1'b0;
  logic       inc_cnt = 1'b0;
  logic       pdi_valid = 1'b0;
  logic       pdo_ready = 1'b0;
  logic       pdi_ready, pdo_valid, busy, done;
  logic       srst, senc, sse, xrst, xenc, xse;
  logic       yrst, yenc, yse, zrst, zenc, zse;
  logic       correct_cnt, tk1s;
  logic [5:0] constant;
  logic [7:0] domain;
  logic [3:0] decrypt;

  always #5 clk = ~clk;

  skinny_round_ctrl #(.ROUNDS(40), .BEATS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mode_decrypt(mode_decrypt), .mode_domain(mode_domain),
    .mode_tk1s(mode_tk1s), .inc_cnt(inc_cnt),
    .pdi_valid(pdi_valid), .pdo_ready(pdo_ready),
    .pdi_ready(pdi_ready), .pdo_valid(pdo_valid),
    .busy(busy), .done(done),
    .srst(srst), .senc(senc), .sse(sse),
    .xrst(xrst), .xenc(xenc), .xse(xse),
    .yrst(yrst), .yenc(yenc), .yse(yse),
    .zrst(zrst), .zenc(zenc), .zse(zse),
    .correct_cnt(correct_cnt), .tk1s(tk1s),
    .constant(constant), .domain(domain), .decrypt(decrypt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Published SKINNY round-constant list
  logic [5:0] rc_tab [0:39] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

  typedef struct packed { logic [5:0] rc; logic t; } round_t;
  typedef struct packed { logic cc; logic [7:0] dom; } rev_t;

  round_t     exp_round[$];
  rev_t       exp_rev[$];
  logic [3:0] exp_dec[$];
  int         exp_done[$];

  int ls_a[4];
  int us_a[4];

  bit mon_en = 1'b0;
  int ld_cnt = 0;
  int ul_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (senc) begin
        if (exp_round.size() == 0) begin
          chk("unexpected_round", 32'(senc), 32'd0);
        end else begin
          round_t r;
          r = exp_round.pop_front();
          chk("round_const", 32'(constant), 32'(r.rc));
          chk("round_tk1s", 32'(tk1s), 32'(r.t));
          chk("round_enables", {28'd0, xenc, yenc, zenc, sse}, 32'b1110);
        end
      end
      if (busy) begin
        chk("excl_senc_sse", 32'(senc & sse), 32'd0);
        chk("excl_xse_xenc", 32'(xse & xenc), 32'd0);
      end
      if (zse) begin
        if (exp_rev.size() == 0) begin
          chk("unexpected_revert", 32'(zse), 32'd0);
        end else begin
          rev_t v;
          v = exp_rev.pop_front();
          chk("revert_correct_cnt", 32'(correct_cnt), 32'(v.cc));
          chk("revert_domain", 32'(domain), 32'(v.dom));
          chk("revert_xse_yse_sse", {29'd0, xse, yse, sse}, 32'b110);
        end
      end else if (busy) begin
        chk("correct_cnt_outside_revert", 32'(correct_cnt), 32'd0);
      end
      if (pdi_ready && sse) ld_cnt++;
      if (pdo_valid && sse) begin
        ul_cnt++;
        if (exp_dec.size() == 0) begin
          chk("unexpected_unload_beat", 32'(sse), 32'd0);
        end else begin
          chk("unload_decrypt", 32'(decrypt), 32'(exp_dec.pop_front()));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
        chk("done_busy", 32'(busy), 32'd0);
        chk("load_sse_count", 32'(ld_cnt), 32'd4);
        chk("unload_sse_count", 32'(ul_cnt), 32'd4);
        ld_cnt = 0;
        ul_cnt = 0;
      end
      if (!busy) begin
        chk("idle_outputs", {18'd0, constant, domain}, 32'd0);
        chk("idle_decrypt", 32'(decrypt), 32'd0);
      end
      if (rst) begin
        ld_cnt = 0;
        ul_cnt = 0;
      end
    end
  end

  // -------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one block using ls_a/us_a as per-beat stall plans. Called at #1
  // in a cycle where the DUT is expected idle (or in its done cycle).
  // abort_at >= 0 asserts rst during that round index instead of finishing.
  task automatic run_block(input logic [3:0] dec, input logic [7:0] dom,
                           input logic t, input logic inc,
                           input bit hold_start, input int abort_at);
    int acc;
    int stalls;
    int nr;
    mode_decrypt = dec;
    mode_domain  = dom;
    mode_tk1s    = t;
    inc_cnt      = inc;
    start        = 1'b1;
    step();
    start = 1'b0;
    acc = cyc;
    // scramble mode inputs: only the accepted values may matter
    mode_decrypt = 4'($urandom);
    mode_domain  = 8'($urandom);
    mode_tk1s    = 1'($urandom);
    inc_cnt      = 1'($urandom);

    stalls = 0;
    for (int b = 0; b < 4; b++) stalls += ls_a[b] + us_a[b];
    nr = (abort_at >= 0) ? abort_at + 1 : 40;
    for (int i = 0; i < nr; i++) exp_round.push_back('{rc: rc_tab[i], t: t});
    if (abort_at < 0) begin
      exp_rev.push_back('{cc: inc, dom: dom});
      for (int b = 0; b < 4; b++) exp_dec.push_back(dec);
      exp_done.push_back(acc + 49 + stalls);
    end

    for (int b = 0; b < 4; b++) begin
      repeat (ls_a[b]) begin pdi_valid = 1'b0; step(); end
      pdi_valid = 1'b1;
      step();
    end

    if (abort_at >= 0) begin
      for (int i = 0; i < abort_at; i++) begin
        pdi_valid = 1'($urandom);
        pdo_ready = 1'($urandom);
        step();
      end
      pdi_valid = 1'b0;
      pdo_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_enables", {28'd0, senc, sse, zse, pdi_ready}, 32'd0);
      chk("abort_constant", 32'(constant), 32'd0);
      chk("abort_rst_flags", {28'd0, srst, xrst, yrst, zrst}, 32'hF);
      return;
    end

    // 40 ROUND cycles + 1 REVERT; handshakes and start must be ignored
    for (int i = 0; i < 41; i++) begin
      pdi_valid = 1'($urandom);
      pdo_ready = 1'($urandom);
      start     = hold_start;
      step();
    end
    start     = 1'b0;
    pdi_valid = 1'b0;

    for (int b = 0; b < 4; b++) begin
      repeat (us_a[b]) begin pdo_ready = 1'b0; step(); end
      pdo_ready = 1'b1;
      step();
    end
    pdo_ready = 1'b0;
  endtask

  task automatic clear_stalls();
    for (int b = 0; b < 4; b++) begin ls_a[b] = 0; us_a[b] = 0; end
  endtask

  initial begin
    clear_stalls();
    #1;
    // reset held two cycles
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_flags", {28'd0, srst, xrst, yrst, zrst}, 32'hF);
      chk("rst_status", {30'd0, busy, done}, 32'd0);
      chk("rst_enables", {22'd0, senc, sse, xenc, xse, yenc, yse, zenc, zse,
                          pdi_ready, pdo_valid}, 32'd0);
      chk("rst_constant", 32'(constant), 32'd0);
      if (k == 0) step();
    end
    rst = 1'b0;
    step();
    chk("post_rst_flags", {28'd0, srst, xrst, yrst, zrst}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("idle_status", {30'd0, busy, done}, 32'd0);
      chk("idle_enables", {22'd0, senc, sse, xenc, xse, yenc, yse, zenc, zse,
                           correct_cnt, tk1s}, 32'd0);
      step();
    end

    // single block, no stalls, counter advance with domain 2C
    run_block(4'hA, 8'h2C, 1'b1, 1'b1, 1'b0, -1);
    repeat (3) step();

    // stalls: pdi_valid low 3 cycles on beat 2, pdo_ready low 2 on beat 0;
    // counter held
    ls_a[2] = 3;
    us_a[0] = 2;
    run_block(4'h5, 8'h2C, 1'b0, 1'b0, 1'b0, -1);
    clear_stalls();
    // back-to-back from the done cycle, start held through ROUND
    run_block(4'h3, 8'h91, 1'b1, 1'b0, 1'b1, -1);
    repeat (2) step();

    // randomized blocks
    for (int n = 0; n < 8; n++) begin
      for (int b = 0; b < 4; b++) begin
        ls_a[b] = int'($urandom_range(0, 2));
        us_a[b] = int'($urandom_range(0, 2));
      end
      run_block(4'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), -1);
      if ($urandom_range(0, 1) == 0) repeat (int'($urandom_range(1, 3))) step();
    end
    clear_stalls();
    repeat (2) step();

    // reset mid-round, then a fresh block from constant 01
    run_block(4'h7, 8'h44, 1'b1, 1'b1, 1'b0, 20);
    step();
    run_block(4'hC, 8'h19, 1'b0, 1'b1, 1'b0, -1);
    repeat (5) step();

    chk("rounds_left", 32'(exp_round.size()), 32'd0);
    chk("reverts_left", 32'(exp_rev.size()), 32'd0);
    chk("unloads_left", 32'(exp_dec.size()), 32'd0);
    chk("dones_left", 32'(exp_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
